// File: rtl/pwm_voice_arbiter.sv
// Round-robin owner arbiter for a single PWM voice: grants one note sequencer at a
// time, forwards its phase delta / envelope, and inserts a silent gap after release.

module pwm_voice_lane (
  input  logic        sel,
  input  logic [31:0] pd,
  input  logic [8:0]  env,
  output logic [31:0] pd_m,
  output logic [8:0]  env_m
);
  assign pd_m  = sel ? pd  : '0;
  assign env_m = sel ? env : '0;
endmodule

module pwm_voice_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 3325336,
  parameter int GAP_CLKS = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ*32-1:0]  i_phase_delta,
  input  logic [NUM_REQ*9-1:0]   i_envelope,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_active,
  output logic                   o_new_note,
  output logic [31:0]            o_phase_delta,
  output logic [8:0]             o_envelope
);
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [31:0]   HOLD_LAST = 32'(MAX_HOLD - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state, state_nx;
  logic [LW-1:0]      last, last_nx, winner, sel, idx;
  logic [31:0]        hold_cnt, hold_nx;
  logic [GW-1:0]      gap_cnt, gap_nx;
  logic [NUM_REQ-1:0] grant_nx, sel_oh;
  logic               active_nx, new_note_nx, found, hold_expire;
  logic [31:0]        pd_nx, sel_pd;
  logic [8:0]         env_nx, sel_env;

  logic [NUM_REQ-1:0][31:0] pd_m;
  logic [NUM_REQ-1:0][8:0]  env_m;

  // Rotating search: the slot after the previous winner has top priority.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = LW'((int'(last) + i) % NUM_REQ);
      if (!found && i_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // In IDLE the data path already looks at the incoming winner so the first
  // sample lands together with the grant.
  assign sel    = (state == IDLE) ? winner : last;
  assign sel_oh = NUM_REQ'(1) << sel;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    pwm_voice_lane u_lane (
      .sel   (sel_oh[k]),
      .pd    (i_phase_delta[32*k +: 32]),
      .env   (i_envelope[9*k +: 9]),
      .pd_m  (pd_m[k]),
      .env_m (env_m[k])
    );
  end

  always_comb begin
    sel_pd  = '0;
    sel_env = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_pd  = sel_pd  | pd_m[k];
      sel_env = sel_env | env_m[k];
    end
  end

  assign hold_expire = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nx    = state;
    last_nx     = last;
    hold_nx     = hold_cnt;
    gap_nx      = gap_cnt;
    grant_nx    = '0;
    active_nx   = 1'b0;
    new_note_nx = 1'b0;
    pd_nx       = '0;
    env_nx      = '0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_nx    = GRANT;
          last_nx     = winner;
          hold_nx     = '0;
          grant_nx    = sel_oh;
          active_nx   = 1'b1;
          new_note_nx = 1'b1;
          pd_nx       = sel_pd;
          env_nx      = sel_env;
        end
      end
      GRANT: begin
        if (!i_req[last] || hold_expire) begin
          state_nx = (GAP_CLKS == 0) ? IDLE : GAP;
          gap_nx   = '0;
          hold_nx  = '0;
        end else begin
          hold_nx   = hold_cnt + 32'd1;
          grant_nx  = sel_oh;
          active_nx = 1'b1;
          pd_nx     = sel_pd;
          env_nx    = sel_env;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
          gap_nx   = '0;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      last          <= LW'(NUM_REQ - 1);
      hold_cnt      <= '0;
      gap_cnt       <= '0;
      o_grant       <= '0;
      o_active      <= 1'b0;
      o_new_note    <= 1'b0;
      o_phase_delta <= '0;
      o_envelope    <= '0;
    end else begin
      state         <= state_nx;
      last          <= last_nx;
      hold_cnt      <= hold_nx;
      gap_cnt       <= gap_nx;
      o_grant       <= grant_nx;
      o_active      <= active_nx;
      o_new_note    <= new_note_nx;
      o_phase_delta <= pd_nx;
      o_envelope    <= env_nx;
    end
  end
endmodule

// File: tb/tb_pwm_voice_arbiter.sv
// Two arbiters (hold limit + gap, and unlimited/no-gap) on shared stimulus, each
// compared every clock against a timestamp-based reference model.

module tb_pwm_voice_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] pd_bus;
  logic [35:0]  env_bus;

  logic [3:0]  g_a, g_b;
  logic        act_a, act_b, nn_a, nn_b;
  logic [31:0] pd_a, pd_b;
  logic [8:0]  env_a, env_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_voice_arbiter #(.NUM_REQ(4), .MAX_HOLD(100), .GAP_CLKS(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_phase_delta(pd_bus),
    .i_envelope(env_bus), .o_grant(g_a), .o_active(act_a), .o_new_note(nn_a),
    .o_phase_delta(pd_a), .o_envelope(env_a));

  pwm_voice_arbiter #(.NUM_REQ(4), .MAX_HOLD(0), .GAP_CLKS(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_phase_delta(pd_bus),
    .i_envelope(env_bus), .o_grant(g_b), .o_active(act_b), .o_new_note(nn_b),
    .o_phase_delta(pd_b), .o_envelope(env_b));

  // Reference model: owner index, edge of grant, edge of last release.
  int mh[2] = '{100, 0};
  int gp[2] = '{16, 0};
  int m_owner[2], m_last[2], m_gstart[2], m_rel[2];
  int k = 0;
  logic [3:0]  e_grant[2];
  logic        e_act[2], e_nn[2];
  logic [31:0] e_pd[2];
  logic [8:0]  e_env[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, k);
    end
  endtask

  task automatic model_clear(input int d);
    e_grant[d] = '0; e_act[d] = 1'b0; e_nn[d] = 1'b0; e_pd[d] = '0; e_env[d] = '0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_last[d] = 3; m_gstart[d] = 0; m_rel[d] = -1000;
      model_clear(d);
    end
  endtask

  task automatic model_drive(input int d, input int o, input logic nn);
    e_grant[d] = 4'b0001 << o;
    e_act[d]   = 1'b1;
    e_nn[d]    = nn;
    e_pd[d]    = pd_bus[32*o +: 32];
    e_env[d]   = env_bus[9*o +: 9];
  endtask

  task automatic model_step();
    k++;
    for (int d = 0; d < 2; d++) begin
      if (m_owner[d] >= 0) begin
        if (!req[m_owner[d]] || (mh[d] != 0 && k - m_gstart[d] == mh[d])) begin
          m_owner[d] = -1;
          m_rel[d]   = k;
          model_clear(d);
        end else begin
          model_drive(d, m_owner[d], 1'b0);
        end
      end else if (req != 0 && k >= m_rel[d] + gp[d] + 1) begin
        for (int i = 1; i <= 4; i++) begin
          if (m_owner[d] < 0 && req[(m_last[d] + i) % 4]) m_owner[d] = (m_last[d] + i) % 4;
        end
        m_last[d]   = m_owner[d];
        m_gstart[d] = k;
        model_drive(d, m_owner[d], 1'b1);
      end else begin
        model_clear(d);
      end
    end
  endtask

  task automatic check_all();
    chk("a_grant", 32'(g_a), 32'(e_grant[0]));
    chk("a_active", 32'(act_a), 32'(e_act[0]));
    chk("a_new_note", 32'(nn_a), 32'(e_nn[0]));
    chk("a_phase", pd_a, e_pd[0]);
    chk("a_env", 32'(env_a), 32'(e_env[0]));
    chk("b_grant", 32'(g_b), 32'(e_grant[1]));
    chk("b_active", 32'(act_b), 32'(e_act[1]));
    chk("b_new_note", 32'(nn_b), 32'(e_nn[1]));
    chk("b_phase", pd_b, e_pd[1]);
    chk("b_env", 32'(env_b), 32'(e_env[1]));
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) begin
      pd_bus[32*i +: 32] = $urandom;
      env_bus[9*i +: 9]  = 9'($urandom);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_grant", 32'(g_a), 32'd0);
    chk("rst_a_active", 32'(act_a | nn_a), 32'd0);
    chk("rst_a_data", pd_a | 32'(env_a), 32'd0);
    chk("rst_b_grant", 32'(g_b), 32'd0);
    chk("rst_b_data", pd_b | 32'(env_b) | 32'(act_b), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] gq[$];
  int         lens[$];
  int         run;
  logic [3:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] hx_exp[3] = '{4'b0001, 4'b0010, 4'b0001};
  logic [8:0] env_seq[6] = '{9'd14, 9'd2, 9'd0, 9'd14, 9'd2, 9'd0};

  initial begin
    rst_n = 1'b0; req = '0; pd_bus = '0; env_bus = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_grant", 32'(g_a | g_b), 32'd0);
    chk("reset_out", pd_a | 32'(env_a) | 32'(act_a) | 32'(nn_a), 32'd0);
    rst_n = 1'b1;
    step();

    // Single requester: grant and data appear together on the sampling edge.
    rand_data();
    req = 4'b0100;
    pd_bus[64 +: 32] = 32'h0001_0000;
    env_bus[18 +: 9] = 9'd14;
    step();
    chk("single_grant", 32'(g_a), 32'h4);
    chk("single_new_note", 32'(nn_a), 32'd1);
    chk("single_phase", pd_a, 32'h0001_0000);
    chk("single_env", 32'(env_a), 32'd14);
    step();
    chk("single_new_note_drop", 32'(nn_a), 32'd0);
    req = 4'b0000;
    repeat (20) step();

    // Mid-grant reset with every requester active; pointer returns to slot 0 first.
    req = 4'b1111;
    repeat (5) step();
    mid_reset();
    step();
    chk("post_reset_owner0", 32'(g_a), 32'h1);

    // Round robin: owner drops for one clock after ~50 clocks.
    mid_reset();
    gq.delete();
    for (int n = 0; n < 600 && gq.size() < 5; n++) begin
      rand_data();
      req = 4'b1111;
      if (m_owner[0] >= 0 && k - m_gstart[0] >= 49) req[m_owner[0]] = 1'b0;
      step();
      if (nn_a) gq.push_back(g_a);
    end
    chk("rr_grants", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5; i++) if (i < gq.size()) chk("rr_order", 32'(gq[i]), 32'(rr_exp[i]));

    // Hold expiry: two persistent requesters alternate every 100 clocks.
    mid_reset();
    gq.delete(); lens.delete(); run = 0;
    req = 4'b0011;
    for (int n = 0; n < 300; n++) begin
      rand_data();
      step();
      if (nn_a) gq.push_back(g_a);
      if (act_a) run++;
      else if (run > 0) begin lens.push_back(run); run = 0; end
    end
    chk("hold_grants", 32'(gq.size()), 32'd3);
    for (int i = 0; i < 3; i++) if (i < gq.size()) chk("hold_order", 32'(gq[i]), 32'(hx_exp[i]));
    chk("hold_runs", 32'(lens.size()), 32'd2);
    for (int i = 0; i < 2; i++) if (i < lens.size()) chk("hold_len", 32'(lens[i]), 32'd100);

    // Data tracking: owner envelope changes every clock, non-owners randomised.
    mid_reset();
    req = 4'b0011;
    rand_data();
    step();
    for (int i = 0; i < 6; i++) begin
      rand_data();
      env_bus[0 +: 9] = env_seq[i];
      step();
      chk("track_env", 32'(env_a), 32'(env_seq[i]));
    end

    // No gap, no hold limit: next requester follows on the very next edge.
    req = 4'b0010;
    step();
    chk("nogap_release", 32'(g_b), 32'd0);
    step();
    chk("nogap_next", 32'(g_b), 32'h2);
    chk("nogap_new_note", 32'(nn_b), 32'd1);

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      rand_data();
      if ($urandom_range(15) == 0) req = 4'($urandom);
      if ($urandom_range(599) == 0) mid_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
